// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings, func_3 access codes and the timeout fill pattern
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, load right-alignment and misalignment detect
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  func_3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shift,
  output logic        misalign
);
  logic is_b, is_h, unused_sign;
  assign unused_sign = func_3[2];
  assign is_b = func_3[1:0] == F3_SB[1:0];
  assign is_h = func_3[1:0] == F3_SH[1:0];
  // size decode: byte/half select lanes, anything wider is treated as a word
  always_comb begin
    be = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    misalign = is_b ? 1'b0 : is_h ? off[0] : |off;
  end
  assign rdata_shift = rdata >> {off, 3'b000};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for one single-port word memory; MEM_ARB_TIMEOUT_EN adds an ack timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_TIMEOUT_EN
  #(parameter int TIMEOUT = 16)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        i_dm_req,
  input  logic        i_dm_op,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [2:0]  i_dm_func_3,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        bus_err
);
  state_t state, state_n;
  logic fair, if_go, dm_go, if_mis, dm_mis, acc, tmo, done;
  logic [1:0] off, off_q;
  logic [3:0] be;
  logic [31:0] wdata_rep, rdata_shift;
  assign off = state == IDLE ? i_dm_addr[1:0] : off_q;
  mem_lane_align u_align (
    .func_3(i_dm_func_3),
    .off(off),
    .wdata(i_dm_wdata),
    .rdata(i_mem_rdata),
    .be(be),
    .wdata_rep(wdata_rep),
    .rdata_shift(rdata_shift),
    .misalign(dm_mis)
  );
  assign if_mis = |i_if_addr[1:0];
  assign dm_go = i_dm_req & (!i_if_req | !fair);
  assign if_go = i_if_req & (!i_dm_req | fair);
  assign acc = state == IF_ACC || state == DM_ACC;
  assign done = i_mem_ack | tmo;
  assign if_stall = i_if_req & !if_valid;
  assign dm_stall = i_dm_req & !dm_valid;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  // wait counter, zero on entry to an access state
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= acc ? cnt + 1'b1 : '0;
  assign tmo = acc && !i_mem_ack && cnt == LAST;
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: data wins ties unless a fetch already lost once; misaligned requests skip memory
  always_comb begin
    state_n = IDLE;
    if (state == IDLE)
      state_n = dm_go ? (dm_mis ? RESP : DM_ACC) : if_go ? (if_mis ? RESP : IF_ACC) : IDLE;
    else if (acc)
      state_n = done ? RESP : state;
  end
  // registered memory interface, response capture, fairness and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err <= 1'b0;
      fair <= 1'b0;
      off_q <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (state == IDLE) begin
        fair <= if_go ? 1'b0 : (dm_go && i_if_req) ? 1'b1 : fair;
        if (dm_go && dm_mis) begin
          dm_valid <= 1'b1;
          dm_rdata <= '0;
          bus_err <= 1'b1;
        end else if (dm_go) begin
          off_q <= i_dm_addr[1:0];
          mem_req <= 1'b1;
          mem_we <= i_dm_op;
          mem_addr <= {i_dm_addr[31:2], 2'b00};
          mem_wdata <= wdata_rep;
          mem_be <= i_dm_op ? be : 4'b1111;
        end else if (if_go && if_mis) begin
          if_valid <= 1'b1;
          if_rdata <= '0;
          bus_err <= 1'b1;
        end else if (if_go) begin
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= {i_if_addr[31:2], 2'b00};
          mem_be <= 4'b1111;
        end
      end else if (acc && done) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        bus_err <= bus_err | tmo;
        if (state == DM_ACC) begin
          dm_valid <= 1'b1;
          dm_rdata <= tmo ? DEAD_BEEF : rdata_shift;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= tmo ? DEAD_BEEF : i_mem_rdata;
        end
      end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 32-bit word memory between instruction fetch (stage_1) and data access (stage_4).
- Sequences each access as registered request → wait-for-ack → registered response.
- Generates byte enables for SB/SH/SW and right-aligns load data, so stage_4's low-bit sign/zero extension stays correct.
- Drives per-requester stall outputs to the pipeline hazard logic.

Parameters:
- TIMEOUT, 16, max cycles waiting for i_mem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch request; held until if_valid
- i_if_addr  in  32  fetch byte address; word-aligned
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse, fetch complete
- if_stall  out  1  fetch pending, not complete
- i_dm_req  in  1  data request; held until dm_valid
- i_dm_op  in  1  0 load, 1 store (stage_4 op_to_mem_ctr)
- i_dm_addr  in  32  data byte address
- i_dm_wdata  in  32  store data; low bits significant per func_3
- i_dm_func_3  in  3  LB/LH/LW/LBU/LHU/SB/SH/SW encoding
- dm_rdata  out  32  load word shifted right by byte offset
- dm_valid  out  1  one-cycle pulse, data access complete
- dm_stall  out  1  data access pending, not complete
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  32  word address, byte address with [1:0] forced to 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables
- i_mem_ack  in  1  memory completion, one-cycle pulse
- i_mem_rdata  in  32  read word, valid with ack
- bus_err  out  1  sticky error (misalignment; timeout with feature)

Behaviour:
- Clock/reset: one clock (clk); asynchronous active-high reset (rst).
- Reset:
  - State IDLE.
  - All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata, valids and bus_err.
  - fair flag 0.
  - rst mid-access drops mem_req immediately; an ack arriving during reset is ignored.
- FSM states: IDLE, IF_ACC, DM_ACC, RESP.
  - IDLE → DM_ACC if i_dm_req and (!i_if_req or !fair).
  - IDLE → IF_ACC if i_if_req and (!i_dm_req or fair).
  - Data wins ties (older instruction) unless fair=1.
  - fair sets when a fetch loses arbitration and clears when a fetch is granted. A fetch therefore never waits more than one data access.
- Access states (IF_ACC/DM_ACC):
  - mem_* registered on the entry edge; mem_req=1 the cycle after the request is sampled.
  - Hold all mem_* stable until i_mem_ack=1, then → RESP.
- RESP (1 cycle):
  - Pulse if_valid or dm_valid with registered data; mem_req=0.
  - Then → IDLE, re-arbitrate next cycle. No back-to-back grant from RESP.
- Minimum latency request→valid: 3 cycles with same-cycle ack (ack during the first mem_req cycle).
- Stalls: if_stall = i_if_req & !if_valid; dm_stall = i_dm_req & !dm_valid (combinational).
- Store lanes (off = i_dm_addr[1:0]):
  - SB: be = 4'b0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads: mem_be = 4'b1111, mem_we = 0; dm_rdata = i_mem_rdata >> (8*off).
- Fetch: be = 4'b1111, we = 0; if_rdata = i_mem_rdata.
- Misalignment:
  - Cases: SH/LH/LHU with off[0]=1; SW/LW with off≠0; fetch with addr[1:0]≠0.
  - No memory access; go straight to RESP; pulse valid with rdata=0; set bus_err.
- bus_err clears only on rst.
- Requester deasserting req mid-access is illegal; the access completes anyway.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to IF_ACC/DM_ACC and increments each cycle without ack.
  - At count TIMEOUT-1: drop mem_req, → RESP, valid with rdata=32'hDEAD_BEEF, set bus_err.
  - A late ack in IDLE is ignored.
- Undefined: no counter; waits indefinitely for ack.

Decomposition:
- Shared constants header alongside constants.vh: state encodings, func_3 codes, the DEAD_BEEF pattern.
- Reuse existing SB/SH/SW/LB/LH/LW encodings.
- One sub-module: mem_lane_align, combinational. Inputs func_3, off, wdata, rdata; outputs be, wdata_rep, rdata_shift, misalign.

Test Plan:
- SW addr 0x100, wdata 0x12345678, ack after 2 cycles → mem_addr 0x100, be 1111, we 1; dm_valid 4 cycles after req; dm_stall high until then.
- SB addr 0x103, wdata 0xAB → mem_addr 0x100, be 1000, wdata 0xABABABAB; LB same addr, rdata 0xAB000000 → dm_rdata 0x000000AB.
- if_req and dm_req both high from cycle 0, continuous → grant order DM, IF, DM, IF; each fetch delayed by at most one data access.
- LW addr 0x102 → no mem_req, dm_valid with rdata 0, bus_err=1 and stays 1 until rst.
- rst asserted while mem_req=1 awaiting ack → mem_req 0 asynchronously; ack pulse during reset ignored; after release a new fetch completes normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=16, no ack → mem_req drops after 16 cycles; if_valid with 0xDEADBEEF; bus_err=1.
